// File: rtl/sm_accumulator_if.sv
// Operand/result handshake bundle for sm_accumulator.
// master = stream producer/result consumer, slave = the accumulator.
interface sm_accumulator_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_zero;
    logic         out_neg;
    logic         out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_neg, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_neg, out_ovf
    );
endinterface

// File: rtl/sm_accumulator.sv
// Sums a fixed-length stream of LEN 16-bit sign-magnitude operands and presents
// the result with zero/neg/sticky-overflow flags over a valid/ready handshake.
module sm_accumulator #(
    parameter int unsigned N   = 32,
    parameter int unsigned LEN = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    sm_accumulator_if.slave bus
);
    localparam int unsigned CntW = $clog2(LEN + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [15:0]     acc_q, acc_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            accept, done;
    logic [16:0]     add_res;
    logic            unused_in_hi;

    // Returns {carry_out_of_bit14, sign, magnitude}; -0 in or out is normalised to +0.
    function automatic logic [16:0] smadd(input logic [15:0] a, input logic [15:0] b);
        logic [14:0] ma, mb, m;
        logic        sa, sb, s, c;
        logic [15:0] sum;
        ma  = a[14:0];
        mb  = b[14:0];
        sa  = a[15] & (ma != 15'd0);
        sb  = b[15] & (mb != 15'd0);
        sum = {1'b0, ma} + {1'b0, mb};
        c   = 1'b0;
        if (sa == sb) begin
            m = sum[14:0];
            s = sa;
            c = sum[15];
        end else if (ma > mb) begin
            m = ma - mb;
            s = sa;
        end else begin
            m = mb - ma;
            s = sb;
        end
        if (m == 15'd0) s = 1'b0;
        return {c, s, m};
    endfunction

    assign accept       = bus.in_valid & bus.in_ready;
    assign add_res      = smadd(acc_q, bus.in_data[15:0]);
    assign unused_in_hi = ^bus.in_data[N-1:16];

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    acc_d   = 16'd0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (accept) begin
                    acc_d   = add_res[15:0];
                    ovf_d   = ovf_q | add_res[16];
                    count_d = count_q + 1'b1;
                    if (count_q == CntW'(LEN - 1)) state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            acc_q   <= 16'd0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Result fields are masked to zero outside DONE.
    assign done          = (state_q == StDone);
    assign busy          = (state_q != StIdle);
    assign bus.in_ready  = (state_q == StAcc);
    assign bus.out_valid = done;
    assign bus.out_data  = done ? {{(N - 16){1'b0}}, acc_q} : '0;
    assign bus.out_zero  = done & (acc_q[14:0] == 15'd0);
    assign bus.out_neg   = done & acc_q[15];
    assign bus.out_ovf   = done & ovf_q;
endmodule

// File: doc/sm_accumulator.md
Name: sm_accumulator

Overview:
- Downstream consumer of the 16-bit sign-magnitude add datapath. Word format: bit 15 = sign, bits 14:0 = magnitude, bits N-1:16 = 0.
- Accumulates a fixed-length stream of LEN sign-magnitude operands into one running sum.
- Uses valid/ready handshakes on input and output, and reports zero/neg/sticky-overflow flags with the result.
- Used for vector reductions (dot-product tails, row sums) before writeback.

Parameters:
- N, 32, bus width of in_data/out_data; only bits [15:0] carry data.
- LEN, 8, operands accepted per accumulation (1..255).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin a new accumulation (sampled only in IDLE)
- in_valid  input  1  in_data holds an operand
- in_ready  output  1  block accepts an operand this cycle
- in_data  input  N  sign-magnitude operand; bits N-1:16 ignored
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_data  output  N  sign-magnitude sum; bits N-1:16 = 0
- out_zero  output  1  result magnitude == 0
- out_neg  output  1  out_data[15]
- out_ovf  output  1  sticky: a magnitude carry out of bit 14 occurred during this accumulation
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=+0, count=0, ovf=0. All outputs 0.
- FSM states: IDLE, ACC, DONE.
  - IDLE: in_ready=0, out_valid=0. If start=1: next cycle acc=+0, count=0, ovf=0, state=ACC.
  - ACC: in_ready=1. On accept (in_valid & in_ready): acc <= smadd(acc, in_data[15:0]) and count <= count+1.
  - ACC exit: when the accept makes count reach LEN, state=DONE on the next edge.
  - DONE: in_ready=0, out_valid=1. out_data, out_zero, out_neg, out_ovf are held stable. On out_valid & out_ready, state=IDLE on the next edge.
- start is ignored in ACC and DONE. It is not queued.
- Latency:
  - acc reflects an accepted operand one cycle after the accept.
  - out_valid rises in the cycle after the LEN-th accept.
  - Minimum start-to-out_valid = LEN+1 cycles.
- Throughput: one operand per cycle in ACC with no bubbles.
- smadd(a,b), operating on 15-bit magnitudes ma/mb and signs sa/sb:
  - Input -0 (0x8000) is treated as +0.
  - sa==sb: m = ma+mb. Bit 15 of the 16-bit sum sets ovf (sticky). The magnitude wraps mod 2^15. Sign = sa.
  - sa!=sb, ma>mb: m = ma-mb, sign = sa.
  - sa!=sb, mb>ma: m = mb-ma, sign = sb.
  - sa!=sb, ma==mb: m = 0, sign = 0.
  - If the result magnitude is 0 for any reason, sign is forced to 0. A -0 result is never produced.
- out_data/flags in IDLE and ACC: out_data = 0 and all flags = 0. Result fields are only driven in DONE.
- Simultaneous out_ready and start while in DONE: the handshake completes and the FSM goes to IDLE. start is not honoured that cycle; it must be reasserted.
- Reset mid-operation: immediate return to IDLE. The partial sum and count are discarded, and no out_valid is produced.
- count is wide enough for LEN and never wraps within an accumulation.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 3 cycles, then release with start=0.
  - Required: in_ready=0, out_valid=0, busy=0, out_data=0x00000000.
- Unsigned sum:
  - Stimulus: LEN=8, start, then eight operands of 0x00000001, one per cycle.
  - Required: out_valid rises 1 cycle after the last accept; out_data=0x00000008; out_zero=0, out_neg=0, out_ovf=0.
- Mixed signs and -0:
  - Stimulus: 0x0005, 0x8003, 0x8007, 0x0002, 0x8000, 0x0000, 0x0000, 0x0000.
  - Required: out_data=0x00008003, out_neg=1, out_ovf=0.
- Overflow wrap:
  - Stimulus: 0x7FFF, 0x0001, then six 0x0000.
  - Required: out_data=0x00000000, out_zero=1, out_neg=0, out_ovf=1. A following run of eight 0x0001 gives out_ovf=0 and sum 8.
- Backpressure:
  - Stimulus: in_valid toggled 1,0,1,0 during ACC; out_ready held 0 for 5 cycles in DONE; start pulsed during DONE.
  - Required: only valid beats are counted; out_data is stable with in_ready=0 while stalled; start is ignored.
  - Required: after out_ready=1, the FSM returns to IDLE in one cycle.
- Reset mid-run:
  - Stimulus: assert rst after 3 accepts (+100 each), then restart with eight 0x0002.
  - Required: no out_valid from the aborted run; the new result is 0x00000010.
